d_regfile: RTL and testbench
============================

# d_regfile

Architectural register file plus write-back sink for the 5-stage pipeline. It consumes the W-stage outputs of the MEM/WB pipeline register: RegWriteW, MemtoRegW, ReadDataW, ALUOutW and WriteRegW. It forms ResultW, commits it to a 32x32 register array, and serves the two combinational read ports used by the D stage. After reset, a small sequencer zeroes the array and holds the pipeline off with `Busy` until the array is clean.

## Interface
Parameters
- none; fixed geometry: 32 registers x 32 bits, 5-bit addresses.

Ports
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RegWriteW`  in  1  write enable from the MEM/WB register.
- `MemtoRegW`  in  1  result select: 1 = ReadDataW, 0 = ALUOutW.
- `ReadDataW`  in  32  data-memory read value.
- `ALUOutW`  in  32  ALU result.
- `WriteRegW`  in  5  destination register number.
- `A1`  in  5  D-stage read address, port 1 (rs).
- `A2`  in  5  D-stage read address, port 2 (rt).
- `RD1`  out  32  read data, port 1 (combinational).
- `RD2`  out  32  read data, port 2 (combinational).
- `ResultW`  out  32  write-back value, also routed to the hazard-unit forwarding muxes (combinational).
- `Busy`  out  1  registered; high while the array is being cleared; the hazard unit stalls F/D while it is high.

## Operation
- `ResultW` = MemtoRegW ? ReadDataW : ALUOutW.
- The block is always combinational; it does not depend on state.

Sequencer: two states, CLEAR and RUN. A 5-bit counter `cnt` is used only in CLEAR.
- `rst` high at an edge:
  - state <= CLEAR, cnt <= 1, Busy <= 1.
  - No array write happens on that edge.
- CLEAR, rst low:
  - reg[cnt] <= 0 and cnt <= cnt+1.
  - On the edge that clears reg[31], state <= RUN and Busy <= 0.
  - W-stage writes are dropped during CLEAR. They are not queued.
- RUN:
  - If RegWriteW=1 and WriteRegW!=0, then reg[WriteRegW] <= ResultW at the edge.
  - The sequencer stays in RUN until the next `rst`.
- Register 0 reads as 0 in all states. Writes to register 0 are ignored and never stored.
- Reads:
  - RDn = 0 when An=0 or state=CLEAR.
  - Otherwise RDn = reg[An], modified by the bypass rule in Configuration.
- Simultaneous write and read of the same register in RUN:
  - Without bypass, the read returns the old value in that cycle.
  - With bypass, the read returns ResultW.
- Reset mid-clear or mid-run: the clear restarts from register 1. Partially cleared or written contents are overwritten by the new clear pass.

## Timing
Reset values:
- Busy=1.
- state=CLEAR, cnt=1.
- RD1/RD2 read 0 throughout CLEAR.
- ResultW follows its inputs and has no reset value.

Latency:
- Clear:
  - After the last edge with rst=1, exactly 31 further edges clear registers 1..31.
  - Busy falls after the 31st edge.
  - The first W-stage write is accepted at the 32nd edge.
- Write-to-read: a value written at edge k is visible on RDn from edge k onward, i.e. in the cycle after the write.
- Register read ports have no internal pipelining and are purely combinational from An.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In RUN, if RegWriteW=1, WriteRegW!=0 and WriteRegW==An, then RDn = ResultW in the same cycle.
  - This is the write-through path, so the D stage sees W-stage results with no extra stall.
- Not defined:
  - RDn always returns the stored array value.
  - The hazard unit must stall D for one cycle when a D-stage source matches a pending W-stage destination.
- Array, sequencer and ResultW behaviour are identical in both builds.

## Test plan
- Reset then clear:
  - Stimulus: hold rst 3 cycles, release.
  - Required: Busy=1 for exactly 31 edges after release, then 0.
  - Required: RD1 with A1=31 reads 0 throughout.
  - Required: a write of 0xDEADBEEF to r5 issued during CLEAR is dropped, so r5 reads 0 once Busy=0.
- Basic write/read:
  - Stimulus: in RUN, RegWriteW=1, MemtoRegW=0, ALUOutW=0x12345678, WriteRegW=8.
  - Required: after the edge, A1=8 gives RD1=0x12345678.
  - Stimulus: MemtoRegW=1, ReadDataW=0xCAFEF00D to r9.
  - Required: A2=9 gives RD2=0xCAFEF00D, and ResultW=0xCAFEF00D during the write cycle.
- Register 0:
  - Stimulus: write 0xFFFFFFFF to r0.
  - Required: RD1 and RD2 with A=0 read 0 before and after the edge.
- Same-cycle read/write:
  - Stimulus: r3=0x1, write 0x2 to r3 while A1=A2=3.
  - Required with REGFILE_BYPASS_EN: RD1=RD2=0x2 in that cycle.
  - Required without: both read 0x1 in that cycle, and 0x2 after the edge.
- Reset mid-operation:
  - Stimulus: load r7=0xA5A5A5A5, assert rst for 1 cycle, then release.
  - Required: r7 reads 0 and Busy is high for 31 edges.
  - Stimulus: assert rst again 10 cycles into the clear.
  - Required: after the final release, Busy is high for a further full 31 edges.

Source files
------------

// File: rtl/d_regfile_if.sv
// d_regfile_if: W-stage write-back inputs, D-stage read ports and Busy for d_regfile
interface d_regfile_if;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [4:0]  WriteRegW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] ResultW;
  logic        Busy;
  modport master (
    output RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, A1, A2,
    input  RD1, RD2, ResultW, Busy
  );
  modport slave (
    input  RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, A1, A2,
    output RD1, RD2, ResultW, Busy
  );
endinterface

// File: rtl/d_regfile.sv
// d_regfile: 32x32 register file with post-reset clear sequencer; REGFILE_BYPASS_EN enables W-to-D write-through
module d_regfile (
  input logic        clk,
  input logic        rst,
  d_regfile_if.slave rf
);
  typedef enum logic {CLEAR, RUN} stateT;
  stateT       state, nextState;
  logic [4:0]  cnt;
  logic [31:0] regs [32];
  logic        wrEn, hit1, hit2;
  assign rf.ResultW = rf.MemtoRegW ? rf.ReadDataW : rf.ALUOutW;
  assign wrEn = state == RUN && rf.RegWriteW && rf.WriteRegW != 5'd0;
  always_comb begin
    nextState = state;
    nextState = (state == CLEAR && cnt == 5'd31) ? RUN : nextState;
  end
  always_ff @(posedge clk) begin
    state   <= rst ? CLEAR : nextState;
    cnt     <= rst ? 5'd1 : (state == CLEAR ? cnt + 5'd1 : cnt);
    rf.Busy <= rst || nextState == CLEAR;
  end
  // cnt never reaches 0 while clearing, so register 0 is never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) regs[cnt] <= '0;
      else if (wrEn) regs[rf.WriteRegW] <= rf.ResultW;
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign hit1 = wrEn && rf.WriteRegW == rf.A1;
  assign hit2 = wrEn && rf.WriteRegW == rf.A2;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  assign rf.RD1 = (rf.A1 == 5'd0 || state == CLEAR) ? '0 : hit1 ? rf.ResultW : regs[rf.A1];
  assign rf.RD2 = (rf.A2 == 5'd0 || state == CLEAR) ? '0 : hit2 ? rf.ResultW : regs[rf.A2];
endmodule

// File: tb/tb_d_regfile.sv
// tb_d_regfile: directed checks of clear sequencing, write/read, r0 and same-cycle behaviour
module tb_d_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n;
  d_regfile_if rf();
  d_regfile dut (.clk(clk), .rst(rst), .rf(rf));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rf.RegWriteW = 1'b0;
    rf.MemtoRegW = 1'b0;
    rf.ReadDataW = '0;
    rf.ALUOutW   = '0;
    rf.WriteRegW = '0;
  endtask
  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    rf.RegWriteW = 1'b1;
    rf.MemtoRegW = 1'b0;
    rf.ALUOutW   = v;
    rf.WriteRegW = r;
  endtask
  task automatic pulseRst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  // counts edges until Busy drops, checking RD1 reads 0 throughout
  task automatic clearRun(output int edges);
    edges = 0;
    while (rf.Busy && edges < 100) begin
      chk("clrRd1", rf.RD1, 32'h0);
      step();
      edges++;
    end
  endtask
  initial begin
    idle();
    rf.A1 = 5'd31;
    rf.A2 = 5'd0;
    rst = 1'b1;
    repeat (3) step();
    chk("rstBusy", {31'b0, rf.Busy}, 32'h1);
    chk("rstRd1", rf.RD1, 32'h0);
    rst = 1'b0;
    wr(5'd5, 32'hDEADBEEF);
    clearRun(n);
    idle();
    chk("clrLen", n, 32'd31);
    chk("busyLow", {31'b0, rf.Busy}, 32'h0);
    rf.A1 = 5'd5;
    #1 chk("dropWr", rf.RD1, 32'h0);
    wr(5'd8, 32'h12345678);
    #1 chk("resAlu", rf.ResultW, 32'h12345678);
    step();
    idle();
    rf.A1 = 5'd8;
    #1 chk("rdR8", rf.RD1, 32'h12345678);
    rf.RegWriteW = 1'b1;
    rf.MemtoRegW = 1'b1;
    rf.ReadDataW = 32'hCAFEF00D;
    rf.ALUOutW   = 32'h11111111;
    rf.WriteRegW = 5'd9;
    #1 chk("resMem", rf.ResultW, 32'hCAFEF00D);
    step();
    idle();
    rf.A2 = 5'd9;
    #1 chk("rdR9", rf.RD2, 32'hCAFEF00D);
    rf.A1 = 5'd0;
    rf.A2 = 5'd0;
    wr(5'd0, 32'hFFFFFFFF);
    #1 chk("r0Rd1Pre", rf.RD1, 32'h0);
    chk("r0Rd2Pre", rf.RD2, 32'h0);
    step();
    idle();
    #1 chk("r0Rd1Post", rf.RD1, 32'h0);
    chk("r0Rd2Post", rf.RD2, 32'h0);
    wr(5'd3, 32'h1);
    step();
    wr(5'd3, 32'h2);
    rf.A1 = 5'd3;
    rf.A2 = 5'd3;
`ifdef REGFILE_BYPASS_EN
    #1 chk("sameRd1", rf.RD1, 32'h2);
    chk("sameRd2", rf.RD2, 32'h2);
`else
    #1 chk("sameRd1", rf.RD1, 32'h1);
    chk("sameRd2", rf.RD2, 32'h1);
`endif
    step();
    idle();
    #1 chk("afterRd1", rf.RD1, 32'h2);
    chk("afterRd2", rf.RD2, 32'h2);
    wr(5'd7, 32'hA5A5A5A5);
    step();
    idle();
    rf.A1 = 5'd7;
    rf.A2 = 5'd8;
    #1 chk("rdR7", rf.RD1, 32'hA5A5A5A5);
    pulseRst();
    chk("midBusy", {31'b0, rf.Busy}, 32'h1);
    clearRun(n);
    chk("midLen", n, 32'd31);
    chk("r7Clr", rf.RD1, 32'h0);
    chk("r8Clr", rf.RD2, 32'h0);
    wr(5'd7, 32'h5A5A5A5A);
    step();
    idle();
    #1 chk("r7New", rf.RD1, 32'h5A5A5A5A);
    pulseRst();
    repeat (10) step();
    chk("busy10", {31'b0, rf.Busy}, 32'h1);
    pulseRst();
    clearRun(n);
    chk("restartLen", n, 32'd31);
    chk("r7Clr2", rf.RD1, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
